// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: AXI4 default slave that drains any burst and answers every B/R beat with an error response
module axi_decerr_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter logic [1:0] ERR_RESP = 2'b11,
  parameter logic [DATA_W-1:0] FILL_DATA = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [ID_W-1:0]     bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [ID_W-1:0]     arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [1:0]          rresp,
  output logic [DATA_W-1:0]   rdata,
  output logic                rlast,
  output logic [ID_W-1:0]     rid
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e          w_state_q;
  r_state_e          r_state_q;
  logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [ID_W-1:0]   bid_q, rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        len_q, cnt_q;
  logic              unused;
  assign unused = ^{awaddr, awlen, awsize, awburst, wdata, wstrb, araddr, arsize, arburst};
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  // write path: accept AW, swallow W beats up to wlast, then hold B until accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            bid_q     <= awid;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready_q && wlast) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= ERR_RESP;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
  // read path: accept AR, then stream arlen+1 error beats; rlast is precomputed from the next count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            rid_q     <= arid;
            len_q     <= arlen;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= ERR_RESP;
            rdata_q   <= FILL_DATA;
            rlast_q   <= (arlen == 8'd0);
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= (cnt_q + 8'd1 == len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb_axi_decerr_slave: directed vector table plus hand-written burst, concurrency and reset sequences
module tb_axi_decerr_slave;
  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [3:0]  awid = 0, arid = 0;
  logic [7:0]  arlen = 0;
  logic [31:0] addr = 32'h1234_0000, wdata = 32'hdead_beef;
  logic [3:0]  wstrb = 4'hf;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [3:0]  bid, rid;
  logic [31:0] rdata;
  logic        awready2, wready2, bvalid2, arready2, rvalid2, rlast2;
  logic [1:0]  bresp2, rresp2;
  logic [3:0]  bid2, rid2;
  logic [31:0] rdata2;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  axi_decerr_slave dut (
    .i_clk(clk), .i_rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(addr), .awid(awid), .awlen(8'd0), .awsize(3'd2), .awburst(2'd1),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(addr), .arid(arid), .arlen(arlen), .arsize(3'd2), .arburst(2'd1),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );
  axi_decerr_slave #(.ERR_RESP(2'b10)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .awvalid(awvalid), .awready(awready2), .awaddr(addr), .awid(awid), .awlen(8'd0), .awsize(3'd2), .awburst(2'd1),
    .wvalid(wvalid), .wready(wready2), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid2), .bready(bready), .bresp(bresp2), .bid(bid2),
    .arvalid(arvalid), .arready(arready2), .araddr(addr), .arid(arid), .arlen(arlen), .arsize(3'd2), .arburst(2'd1),
    .rvalid(rvalid2), .rready(rready), .rresp(rresp2), .rdata(rdata2), .rlast(rlast2), .rid(rid2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic awv; logic [3:0] awid; logic wv, wl, br, arv; logic [3:0] arid; logic [7:0] arlen; logic rr;
    logic awr, wr, bv; logic [3:0] bid; logic arr, rv, rl; logic [3:0] rid;
  } vec_t;
  vec_t tbl[22];
  int beats, b_seen;
  initial begin
    tbl[0]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,5,1,1,0,0,0,0,0, 1,0,0,0,1,0,0,0};
    tbl[2]  = '{0,0,1,1,1,0,0,0,0, 0,1,0,0,1,0,0,0};
    tbl[3]  = '{0,0,0,0,1,0,0,0,0, 0,0,1,5,1,0,0,0};
    tbl[4]  = '{0,0,0,0,1,1,10,3,1, 1,0,0,0,1,0,0,0};
    tbl[5]  = '{0,0,0,0,0,0,0,0,1, 1,0,0,0,0,1,0,10};
    tbl[6]  = '{0,0,0,0,0,0,0,0,1, 1,0,0,0,0,1,0,10};
    tbl[7]  = '{0,0,0,0,0,0,0,0,1, 1,0,0,0,0,1,0,10};
    tbl[8]  = '{0,0,0,0,0,0,0,0,1, 1,0,0,0,0,1,1,10};
    tbl[9]  = '{1,7,0,0,0,1,3,1,0, 1,0,0,0,1,0,0,0};
    tbl[10] = '{0,0,1,0,0,0,0,0,0, 0,1,0,0,0,1,0,3};
    tbl[11] = '{0,0,1,1,0,0,0,0,1, 0,1,0,0,0,1,0,3};
    tbl[12] = '{1,9,0,0,0,0,0,0,0, 0,0,1,7,0,1,1,3};
    tbl[13] = '{1,9,0,0,0,0,0,0,1, 0,0,1,7,0,1,1,3};
    tbl[14] = '{1,9,0,0,0,0,0,0,0, 0,0,1,7,1,0,0,0};
    tbl[15] = '{1,9,0,0,0,0,0,0,0, 0,0,1,7,1,0,0,0};
    tbl[16] = '{1,9,0,0,0,0,0,0,0, 0,0,1,7,1,0,0,0};
    tbl[17] = '{1,9,0,0,1,0,0,0,0, 0,0,1,7,1,0,0,0};
    tbl[18] = '{1,9,0,0,1,0,0,0,0, 1,0,0,0,1,0,0,0};
    tbl[19] = '{0,0,1,1,1,0,0,0,0, 0,1,0,0,1,0,0,0};
    tbl[20] = '{0,0,0,0,1,0,0,0,0, 0,0,1,9,1,0,0,0};
    tbl[21] = '{0,0,0,0,1,0,0,0,0, 1,0,0,0,1,0,0,0};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rlast, rid, rdata}, 64'd0);
    chk("reset_outputs2", {awready2, wready2, bvalid2, arready2, rvalid2, rlast2}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      awvalid = tbl[i].awv; awid = tbl[i].awid; wvalid = tbl[i].wv; wlast = tbl[i].wl; bready = tbl[i].br;
      arvalid = tbl[i].arv; arid = tbl[i].arid; arlen = tbl[i].arlen; rready = tbl[i].rr;
      chk($sformatf("row%0d awr_wr_bv_arr_rv", i), {awready, wready, bvalid, arready, rvalid},
          {tbl[i].awr, tbl[i].wr, tbl[i].bv, tbl[i].arr, tbl[i].rv});
      if (tbl[i].bv) begin
        chk($sformatf("row%0d bid", i), bid, tbl[i].bid);
        chk($sformatf("row%0d bresp", i), bresp, 2'b11);
        chk($sformatf("row%0d bresp_slverr", i), {bvalid2, bresp2}, 3'b110);
      end
      if (tbl[i].rv) begin
        chk($sformatf("row%0d rid_rlast", i), {rid, rlast}, {tbl[i].rid, tbl[i].rl});
        chk($sformatf("row%0d rresp_rdata", i), {rresp, rdata}, {2'b11, 32'd0});
        chk($sformatf("row%0d rresp_slverr", i), {rvalid2, rresp2}, 3'b110);
      end
    end
    @(negedge clk);
    awvalid = 1; awid = 1; arvalid = 1; arid = 2; arlen = 255; rready = 1; bready = 1; wvalid = 0; wlast = 0;
    chk("conc_both_ready", {awready, arready}, 2'b11);
    beats = 0; b_seen = 0;
    for (int c = 0; c < 300 && beats != 256; c++) begin
      @(negedge clk);
      awvalid = 0; arvalid = 0;
      wvalid = (c == 0); wlast = (c == 0);
      if (bvalid) begin
        b_seen++;
        chk("conc_bid", bid, 4'd1);
      end
      if (rvalid) begin
        chk($sformatf("max_beat%0d rid_rlast", beats), {rid, rlast}, {4'd2, beats == 255});
        beats++;
      end
    end
    chk("max_beat_count", beats, 256);
    chk("conc_b_count", b_seen, 1);
    @(negedge clk);
    chk("max_done_rvalid_arready", {rvalid, arready}, 2'b01);
    arvalid = 1; arid = 4; arlen = 7; rready = 1;
    @(negedge clk);
    arvalid = 0;
    chk("rst_burst_beat1", {rvalid, rlast, rid}, {2'b10, 4'd4});
    @(negedge clk);
    chk("rst_burst_beat2", {rvalid, rlast, rid}, {2'b10, 4'd4});
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midburst_reset_outputs", {awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rlast, rid, rdata}, 64'd0);
    @(negedge clk);
    chk("after_reset_arready", {arready, rvalid}, 2'b10);
    arvalid = 1; arid = 6; arlen = 0;
    @(negedge clk);
    arvalid = 0;
    chk("single_beat", {rvalid, rlast, rid}, {2'b11, 4'd6});
    @(negedge clk);
    chk("single_beat_done", {rvalid, arready}, 2'b01);
    @(negedge clk);
    chk("single_beat_no_extra", rvalid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
